// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the HH:MM:SS countdown timer.
//   timer_state_t : controller states (IDLE, RUN, PAUSE, DONE)
//   hms_t         : one packed BCD time value, h1 in the MSBs, s0 in the LSBs
//   digit limits  : wrap/validation bounds for each BCD digit
//   preset_valid(): checks a preset against the 24-hour and 60-minute/second limits
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic [2:0] s1;
        logic [3:0] s0;
    } hms_t;

    localparam logic [2:0] SEC_TENS_MAX        = 3'd5;
    localparam logic [2:0] MIN_TENS_MAX        = 3'd5;
    localparam logic [3:0] DIG_MAX             = 4'd9;
    localparam logic [1:0] HOUR_MAX_TENS       = 2'd2;
    localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

    // A preset is a legal time of day: 00:00:00 .. 23:59:59.
    function automatic logic preset_valid(input hms_t p);
        logic ok;
        ok = (p.h1 <= HOUR_MAX_TENS) && (p.h0 <= DIG_MAX) &&
             (p.m1 <= MIN_TENS_MAX)  && (p.m0 <= DIG_MAX) &&
             (p.s1 <= SEC_TENS_MAX)  && (p.s0 <= DIG_MAX);
        if ((p.h1 == HOUR_MAX_TENS) && (p.h0 > HOUR_MAX_UNITS_AT_2)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/countdown_timer_hms_digit.sv
// bcd_down_digit: one BCD digit of a down-counter borrow chain.
//   clk, reset (sync, active-low) : clock and reset (reset clears the digit)
//   dec_en   : decrement this cycle (tick for the LSD, borrow of the lower digit otherwise)
//   load     : take load_val this cycle; wins over dec_en
//   load_val : value to load
//   digit    : current value
//   borrow   : combinational, high when the digit is 0 and dec_en is set (it wraps to WRAP)
module bcd_down_digit #(
    parameter int unsigned   W    = 4,
    parameter logic [W-1:0]  WRAP = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         dec_en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] digit,
    output logic         borrow
);

    logic [W-1:0] digit_q;
    logic [W-1:0] digit_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == '0) ? WRAP : digit_q - 1'b1;
        end
    end

    // NOTE: reset is synchronous (sampled on the clock edge), and flops use <= only
    // so every register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = dec_en && (digit_q == '0);

endmodule

// File: rtl/countdown_timer_hms.sv
// countdown_timer_hms: BCD HH:MM:SS countdown timer driven by a 1 Hz tick.
//   clk, reset (sync, active-low)
//   tick                       : 1 Hz enable, one clk wide
//   load + load_h1..load_s0    : preset request and BCD preset digits
//   start / stop               : enter-resume RUN / pause
//   h1..s0                     : current BCD value
//   running, done              : registered state flags (RUN, DONE)
//   expired                    : one-cycle pulse after the tick that reaches 00:00:00
//   load_err                   : one-cycle pulse after a rejected preset
// Build option TIMER_AUTORELOAD_EN: accepted presets are kept in a shadow register and
// reloaded on expiry instead of stopping in DONE.
module countdown_timer_hms
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [1:0] load_h1,
    input  logic [3:0] load_h0,
    input  logic [2:0] load_m1,
    input  logic [3:0] load_m0,
    input  logic [2:0] load_s1,
    input  logic [3:0] load_s0,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] h1,
    output logic [3:0] h0,
    output logic [2:0] m1,
    output logic [3:0] m0,
    output logic [2:0] s1,
    output logic [3:0] s0,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    timer_state_t state_q, state_d;
    logic         expired_q, expired_d;
    logic         load_err_q, load_err_d;

    hms_t preset, cur, load_src;
    logic accept_load, preset_ok, load_ok, preset_zero;
    logic dec_tick, expire_tick, digit_load;
    logic b_s0, b_s1, b_m0, b_m1, b_h0, h1_borrow;

    assign preset = '{h1: load_h1, h0: load_h0, m1: load_m1,
                      m0: load_m0, s1: load_s1, s0: load_s0};
    assign cur    = '{h1: h1, h0: h0, m1: m1, m0: m0, s1: s1, s0: s0};

    assign accept_load = load && (state_q != ST_RUN);
    assign preset_ok   = preset_valid(preset);
    assign load_ok     = accept_load && preset_ok;
    assign preset_zero = (preset == '0);

    // stop on the same edge as a tick pauses without counting.
    assign dec_tick    = tick && (state_q == ST_RUN) && !stop;
    // Expiry is decided from the value before the decrement: 00:00:01 is the last step.
    assign expire_tick = dec_tick && (cur == hms_t'(20'd1));

`ifdef TIMER_AUTORELOAD_EN
    hms_t shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load_ok) begin
            shadow_d = preset;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // The reload overrides the 1 -> 0 decrement of the expiring tick.
    assign digit_load = load_ok || expire_tick;
    assign load_src   = load_ok ? preset : shadow_q;
`else
    assign digit_load = load_ok;
    assign load_src   = preset;
`endif

    bcd_down_digit #(.W(4), .WRAP(DIG_MAX)) u_s0 (
        .clk(clk), .reset(reset), .dec_en(dec_tick), .load(digit_load),
        .load_val(load_src.s0), .digit(s0), .borrow(b_s0));
    bcd_down_digit #(.W(3), .WRAP(SEC_TENS_MAX)) u_s1 (
        .clk(clk), .reset(reset), .dec_en(b_s0), .load(digit_load),
        .load_val(load_src.s1), .digit(s1), .borrow(b_s1));
    bcd_down_digit #(.W(4), .WRAP(DIG_MAX)) u_m0 (
        .clk(clk), .reset(reset), .dec_en(b_s1), .load(digit_load),
        .load_val(load_src.m0), .digit(m0), .borrow(b_m0));
    bcd_down_digit #(.W(3), .WRAP(MIN_TENS_MAX)) u_m1 (
        .clk(clk), .reset(reset), .dec_en(b_m0), .load(digit_load),
        .load_val(load_src.m1), .digit(m1), .borrow(b_m1));
    bcd_down_digit #(.W(4), .WRAP(DIG_MAX)) u_h0 (
        .clk(clk), .reset(reset), .dec_en(b_m1), .load(digit_load),
        .load_val(load_src.h0), .digit(h0), .borrow(b_h0));
    bcd_down_digit #(.W(2), .WRAP(HOUR_MAX_TENS)) u_h1 (
        .clk(clk), .reset(reset), .dec_en(b_h0), .load(digit_load),
        .load_val(load_src.h1), .digit(h1), .borrow(h1_borrow));

    // RUN is only entered with a nonzero value and left on reaching zero,
    // so the top digit can never borrow.
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !h1_borrow);

    // Priority: load > stop > start; a load in RUN is simply not accepted.
    always_comb begin
        state_d    = state_q;
        expired_d  = expire_tick;
        load_err_d = accept_load && !preset_ok;
        if (accept_load) begin
            if (preset_ok) begin
                state_d = preset_zero ? ST_IDLE : ST_PAUSE;
            end
        end else if (stop && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (start && (state_q == ST_PAUSE)) begin
            state_d = ST_RUN;
        end else if (expire_tick) begin
`ifdef TIMER_AUTORELOAD_EN
            state_d = ST_RUN;
`else
            state_d = ST_DONE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign running  = (state_q == ST_RUN);
`ifdef TIMER_AUTORELOAD_EN
    assign done     = 1'b0;
`else
    assign done     = (state_q == ST_DONE);
`endif
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// tb_countdown_timer_hms: self-checking bench for countdown_timer_hms.
// The reference model tracks the remaining time as a plain count of seconds and
// converts it to BCD digits for comparison on every falling clock edge; directed
// sequences add hand-computed literal expectations.
module tb_countdown_timer_hms;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0] load_h1 = '0;
    logic [3:0] load_h0 = '0;
    logic [2:0] load_m1 = '0;
    logic [3:0] load_m0 = '0;
    logic [2:0] load_s1 = '0;
    logic [3:0] load_s0 = '0;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
    logic       running, done, expired, load_err;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    countdown_timer_hms dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_h1(load_h1), .load_h0(load_h0), .load_m1(load_m1),
        .load_m0(load_m0), .load_s1(load_s1), .load_s0(load_s0),
        .start(start), .stop(stop),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .running(running), .done(done), .expired(expired), .load_err(load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int   m_sec = 0, m_shadow = 0, m_st = M_IDLE;
    logic m_exp = 1'b0, m_err = 1'b0;

    function automatic logic [19:0] to_bcd(input int t);
        int hh, mm, ss;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        return {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk) begin
        int hours, value;
        logic valid;
        m_exp = 1'b0;
        m_err = 1'b0;
        if (!reset) begin
            m_sec = 0; m_shadow = 0; m_st = M_IDLE;
        end else if (load && m_st != M_RUN) begin
            hours = int'(load_h1) * 10 + int'(load_h0);
            valid = (load_h0 <= 9) && (hours <= 23) && (load_m1 <= 5) &&
                    (load_m0 <= 9) && (load_s1 <= 5) && (load_s0 <= 9);
            value = hours * 3600 + (int'(load_m1) * 10 + int'(load_m0)) * 60 +
                    int'(load_s1) * 10 + int'(load_s0);
            if (valid) begin
                m_sec = value; m_shadow = value;
                m_st  = (value != 0) ? M_PAUSE : M_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if (stop && m_st == M_RUN) begin
            m_st = M_PAUSE;
        end else if (start && m_st == M_PAUSE) begin
            m_st = M_RUN;
        end else if (tick && m_st == M_RUN) begin
            m_sec = m_sec - 1;
            if (m_sec == 0) begin
                m_exp = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                m_sec = m_shadow;
`else
                m_st = M_DONE;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_digits", 32'({h1, h0, m1, m0, s1, s0}), 32'(to_bcd(m_sec)));
            check("model_running", 32'(running), 32'(m_st == M_RUN));
            check("model_done", 32'(done), 32'(m_st == M_DONE));
            check("model_expired", 32'(expired), 32'(m_exp));
            check("model_load_err", 32'(load_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic t, input logic l, input logic st, input logic sp);
        tick = t; load = l; start = st; stop = sp;
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic do_load(input int a, input int b, input int c, input int d,
                           input int e, input int f, input logic with_start);
        load_h1 = 2'(a); load_h0 = 4'(b); load_m1 = 3'(c);
        load_m0 = 4'(d); load_s1 = 3'(e); load_s0 = 4'(f);
        step(1'b0, 1'b1, with_start, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [31:0] digits();
        return 32'({h1, h0, m1, m0, s1, s0});
    endfunction

    initial begin
        reset = 1'b0;
        step(0, 0, 0, 0);
        cmp_en = 1'b1;
        step(0, 0, 0, 0);
        check("reset_digits", digits(), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b1;

        // Reset mid-run from 00:01:30.
        do_load(0, 0, 0, 1, 3, 0, 1'b0);
        step(0, 0, 1, 0);
        ticks(5);
        check("mid_run_value", digits(), 32'({2'd0, 4'd0, 3'd0, 4'd1, 3'd2, 4'd5}));
        reset = 1'b0;
        step(0, 0, 0, 0);
        reset = 1'b1;
        check("mid_reset_digits", digits(), 32'd0);
        check("mid_reset_running", 32'(running), 32'd0);
        check("mid_reset_flags", 32'({done, expired, load_err}), 32'd0);

        // Full borrow chain: 10:00:00 -> 09:59:59.
        do_load(1, 0, 0, 0, 0, 0, 1'b0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        check("borrow_value", digits(), 32'({2'd0, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9}));
        check("borrow_no_expire", 32'(expired), 32'd0);
        step(0, 0, 0, 1);

        // Expiry from 00:00:02.
        do_load(0, 0, 0, 0, 0, 2, 1'b0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("expire_pulse", 32'(expired), 32'd1);
`ifdef TIMER_AUTORELOAD_EN
        check("expire_reload", digits(), 32'd2);
        check("expire_still_running", 32'(running), 32'd1);
`else
        check("expire_digits", digits(), 32'd0);
        check("expire_done", 32'(done), 32'd1);
`endif
        step(0, 0, 0, 0);
        check("expire_one_cycle", 32'(expired), 32'd0);
        step(1, 0, 0, 0);
        check("expire_no_second", 32'(expired), 32'd0);
        step(0, 0, 0, 1);

        // Invalid presets, then the largest valid one.
        do_load(2, 4, 0, 0, 0, 0, 1'b0);
        check("err_24h", 32'(load_err), 32'd1);
        do_load(1, 2, 6, 0, 0, 0, 1'b0);
        check("err_60m", 32'(load_err), 32'd1);
        do_load(2, 3, 5, 9, 5, 9, 1'b0);
        check("max_accept_err", 32'(load_err), 32'd0);
        check("max_accept_value", digits(), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9}));

        // stop + tick in RUN: pause without counting.
        step(0, 0, 1, 0);
        step(1, 0, 0, 1);
        check("stop_tick_running", 32'(running), 32'd0);
        check("stop_tick_value", digits(), 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9}));

        // load + start in PAUSE: load wins, stays paused.
        do_load(0, 1, 0, 2, 0, 3, 1'b1);
        check("load_start_value", digits(), 32'({2'd0, 4'd1, 3'd0, 4'd2, 3'd0, 4'd3}));
        check("load_start_paused", 32'(running), 32'd0);

        // load in RUN is ignored silently.
        step(0, 0, 1, 0);
        do_load(0, 5, 0, 0, 0, 0, 1'b0);
        check("run_load_no_err", 32'(load_err), 32'd0);
        check("run_load_value", digits(), 32'({2'd0, 4'd1, 3'd0, 4'd2, 3'd0, 4'd3}));
        check("run_load_running", 32'(running), 32'd1);
        step(0, 0, 0, 1);

        // Hours tens borrow: 20:00:00 -> 19:59:59.
        do_load(2, 0, 0, 0, 0, 0, 1'b0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        check("h1_borrow_value", digits(), 32'({2'd1, 4'd9, 3'd5, 4'd9, 3'd5, 4'd9}));
        step(0, 0, 0, 1);

        // Zero preset goes to IDLE, where start is ignored.
        do_load(0, 0, 0, 0, 0, 0, 1'b0);
        step(0, 0, 1, 0);
        check("zero_start_ignored", 32'(running), 32'd0);

        // Auto-reload / plain expiry from 00:00:03.
        do_load(0, 0, 0, 0, 0, 3, 1'b0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reload_pulse1", 32'(expired), 32'd1);
`ifdef TIMER_AUTORELOAD_EN
        check("reload_value", digits(), 32'd3);
        check("reload_running", 32'(running), 32'd1);
        ticks(2);
        step(1, 0, 0, 0);
        check("reload_pulse2", 32'(expired), 32'd1);
`else
        check("noreload_done", 32'(done), 32'd1);
        ticks(3);
        check("noreload_hold", digits(), 32'd0);
`endif
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
